// File: rtl/code_entry_if.sv
// Keypad-to-code-entry bus: decoded key events in, six-digit code plus status out.
interface code_entry_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] a1, a2, a3, a4, a5, a6;
   logic [2:0] count;
   logic       full;
   logic       s;
   logic       err;
   logic       timeout;

   modport master (output key_valid, key_code,
                   input  a1, a2, a3, a4, a5, a6, count, full, s, err, timeout);
   modport slave  (input  key_valid, key_code,
                   output a1, a2, a3, a4, a5, a6, count, full, s, err, timeout);
endinterface

// File: rtl/code_entry.sv
// Six-digit keypad entry buffer with backspace/clear/enter and a one-cycle compare strobe.
// Define CODE_ENTRY_TIMEOUT_EN to discard abandoned partial entries after TIMEOUT_CYCLES idle cycles.
module code_entry #(
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic         clk,
   input  logic         rst,
   code_entry_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ENTRY, CHECK} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [5:0][3:0] dig;
   logic [2:0]      cnt;
   logic            full_q, s_q, err_q, to_q;
   logic            key_dig;
   logic            expire;

   assign key_dig = (bus.key_code <= 4'h9);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         dig    <= '1;
         cnt    <= '0;
         full_q <= 1'b0;
         s_q    <= 1'b0;
         err_q  <= 1'b0;
         to_q   <= 1'b0;
      end else begin
         s_q   <= 1'b0;
         err_q <= 1'b0;
         to_q  <= 1'b0;
         case (state)
            IDLE, ENTRY: begin
               if (bus.key_valid) begin
                  if (key_dig) begin
                     if (cnt != 3'd6) begin
                        dig[cnt] <= bus.key_code;
                        cnt      <= cnt + 3'd1;
                        full_q   <= (cnt == 3'd5);
                        state    <= ENTRY;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else begin
                     case (bus.key_code)
                        4'hA: if (cnt != 3'd0) begin
                           dig[3'(cnt - 3'd1)] <= 4'hF;
                           cnt    <= cnt - 3'd1;
                           full_q <= 1'b0;
                           if (cnt == 3'd1) state <= IDLE;
                        end
                        4'hB: begin
                           dig    <= '1;
                           cnt    <= '0;
                           full_q <= 1'b0;
                           state  <= IDLE;
                        end
                        4'hC: if (cnt == 3'd6) state <= CHECK;
                              else             err_q <= 1'b1;
                        default: ;
                     endcase
                  end
               end else if (expire) begin
                  dig    <= '1;
                  cnt    <= '0;
                  full_q <= 1'b0;
                  state  <= IDLE;
                  to_q   <= 1'b1;
               end
            end
            // First CHECK cycle raises s; second clears the buffer, and a digit
            // arriving on that same edge starts the next code.
            CHECK: begin
               if (!s_q) begin
                  s_q <= 1'b1;
               end else begin
                  dig    <= '1;
                  cnt    <= '0;
                  full_q <= 1'b0;
                  state  <= IDLE;
                  if (bus.key_valid && key_dig) begin
                     dig[0] <= bus.key_code;
                     cnt    <= 3'd1;
                     state  <= ENTRY;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CODE_ENTRY_TIMEOUT_EN
   logic [CW-1:0] tcnt;

   assign expire = (state == ENTRY) && !bus.key_valid && (tcnt == TMAX);

   always_ff @(posedge clk) begin
      if (rst || state != ENTRY || bus.key_valid || expire) tcnt <= '0;
      else                                                   tcnt <= tcnt + 1'b1;
   end
`else
   assign expire = 1'b0;
`endif

   assign bus.a1      = dig[0];
   assign bus.a2      = dig[1];
   assign bus.a3      = dig[2];
   assign bus.a4      = dig[3];
   assign bus.a5      = dig[4];
   assign bus.a6      = dig[5];
   assign bus.count   = cnt;
   assign bus.full    = full_q;
   assign bus.s       = s_q;
   assign bus.err     = err_q;
   assign bus.timeout = to_q;
endmodule

// File: tb/tb_code_entry.sv
// Randomized + directed bench for code_entry against a queue-based reference model.
module tb_code_entry;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   code_entry_if bus();

   code_entry #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: the entered code is a queue of digits; a confirmed code
   // spends two cycles in the compare phase (ph 2 -> strobe, ph 1 -> clear).
   int q[$];
   int ph   = 0;
   int idle = 0;
   bit m_s, m_err, m_to;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dut_a(input int i);
      case (i)
         0: return int'(bus.a1);
         1: return int'(bus.a2);
         2: return int'(bus.a3);
         3: return int'(bus.a4);
         4: return int'(bus.a5);
         default: return int'(bus.a6);
      endcase
   endfunction

   task automatic model_step(input bit kv, input int kc, input bit r);
      m_s = 0; m_err = 0; m_to = 0;
      if (r) begin
         q.delete(); ph = 0; idle = 0;
      end else if (ph == 2) begin
         ph = 1; m_s = 1;
      end else if (ph == 1) begin
         ph = 0; q.delete(); idle = 0;
         if (kv && kc <= 9) q.push_back(kc);
      end else if (kv) begin
         idle = 0;
         if (kc <= 9) begin
            if (q.size() < 6) q.push_back(kc);
            else              m_err = 1;
         end else if (kc == 10) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (kc == 11) begin
            q.delete();
         end else if (kc == 12) begin
            if (q.size() == 6) ph = 2;
            else               m_err = 1;
         end
      end else if (q.size() > 0) begin
`ifdef CODE_ENTRY_TIMEOUT_EN
         idle++;
         if (idle == TO) begin
            q.delete(); m_to = 1; idle = 0;
         end
`endif
      end else begin
         idle = 0;
      end
   endtask

   task automatic cmp_all();
      for (int i = 0; i < 6; i++)
         chk($sformatf("a%0d", i + 1), dut_a(i), (i < q.size()) ? q[i] : 15);
      chk("count",   int'(bus.count),   q.size());
      chk("full",    int'(bus.full),    int'(q.size() == 6));
      chk("s",       int'(bus.s),       int'(m_s));
      chk("err",     int'(bus.err),     int'(m_err));
      chk("timeout", int'(bus.timeout), int'(m_to));
   endtask

   task automatic cyc(input bit kv, input int kc, input bit r = 1'b0);
      @(negedge clk);
      bus.key_valid = kv;
      bus.key_code  = 4'(kc);
      rst           = r;
      @(posedge clk);
      model_step(kv, kc, r);
      #1 cmp_all();
   endtask

   task automatic key(input int kc);
      cyc(1'b1, kc);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0);
   endtask

   task automatic six(input int base);
      for (int i = 0; i < 6; i++) key((base + i) % 10);
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b1);

      // full code, enter, strobe, clear
      six(1); key(12); idle_n(3);
      // partial enter rejected
      key(7); key(8); key(9); key(12); idle_n(2); key(11);
      // backspace down through empty
      key(1); key(2); key(3); key(10); key(10); key(10); key(10); idle_n(1);
      // overfull digit, then clears
      six(4); key(9); key(11); key(11);
      // ignored codes
      key(13); key(14); key(15); key(3); key(15); key(11);
      // inactivity timeout and key on the expiry edge
      key(5); idle_n(TO + 3); key(11);
      key(5); idle_n(TO - 1); key(7); idle_n(2); key(11);
      // reset mid-entry and during CHECK
      key(4); cyc(1'b0, 0, 1'b1);
      six(2); key(12); cyc(1'b0, 0, 1'b1); idle_n(1);
      // keys during the strobe cycle are dropped
      six(3); key(12); key(5); idle_n(2);
      six(0); key(12); key(12); key(10); idle_n(2);
      six(7); key(12); cyc(1'b1, 12); cyc(1'b1, 11); idle_n(1);

      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2)       cyc(1'b0, 0, 1'b1);
         else if (r < 40) cyc(1'b0, int'($urandom_range(0, 15)));
         else if (r < 75) key(int'($urandom_range(0, 9)));
         else if (r < 85) key(12);
         else if (r < 92) key(10);
         else if (r < 94) key(11);
         else if (r < 97) key(int'($urandom_range(13, 15)));
         else             idle_n(int'($urandom_range(10, 20)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
